// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed 7-segment scan driver.
// Glyphs are active-low {g,f,e,d,c,b,a}; codes are 5-bit display codes.
package seg_pkg;

    localparam int unsigned CODE_W  = 5;
    localparam int unsigned DIGITS  = 4;
    localparam int unsigned FRAME_W = CODE_W * DIGITS;
    localparam int unsigned SEG_W   = 7;

    typedef logic [DIGITS-1:0][CODE_W-1:0] frame_t;

    localparam logic [CODE_W-1:0] CODE_BLANK   = 5'd31;
    localparam logic [CODE_W-1:0] CODE_FIVE_DP = 5'd26;

    // Hex glyph table, entry 0 is the rightmost element.
    localparam logic [15:0][SEG_W-1:0] GLYPH_HEX = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08,
        7'h10, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19,
        7'h30, 7'h24, 7'h79, 7'h40
    };

    localparam logic [SEG_W-1:0] GLYPH_DASH = 7'h3F;
    localparam logic [SEG_W-1:0] GLYPH_OFF  = 7'h7F;

endpackage

// File: rtl/seg_glyph.sv
// Combinational decode of a 5-bit display code to active-low {dp, seg[6:0]}.
module seg_glyph
    import seg_pkg::*;
(
    input  logic [CODE_W-1:0]  code,
    output logic [SEG_W:0]     glyph_c
);

    always_comb begin
        glyph_c = {1'b1, GLYPH_DASH};
        if (!code[CODE_W-1]) begin
            glyph_c = {1'b1, GLYPH_HEX[code[3:0]]};
        end else if (code == CODE_FIVE_DP) begin
            glyph_c = {1'b0, GLYPH_HEX[5]};
        end else if (code == CODE_BLANK) begin
            glyph_c = {1'b1, GLYPH_OFF};
        end
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit common-anode scan driver: per-frame snapshot of the code word,
// programmable dwell, and blanked dead time at the start of every dwell.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 50000,
    parameter int unsigned DEAD     = 2000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [FRAME_W-1:0] din,
    output logic [DIGITS-1:0]  an,
    output logic [SEG_W-1:0]   seg,
    output logic               dp,
    output logic               frame_tick
);

    localparam int unsigned CNT_W = $clog2(SCAN_DIV);

    logic [CNT_W-1:0]  cnt;
    logic [1:0]        digit;
    frame_t            frame;
    logic [CODE_W-1:0] code_c;
    logic [SEG_W:0]    glyph_c;
    logic              frame_start_c;
    logic              dwell_end_c;

    assign code_c        = frame[digit];
    assign frame_start_c = (cnt == '0) && (digit == 2'd0);
    assign dwell_end_c   = (cnt == CNT_W'(SCAN_DIV - 1));

    seg_glyph u_glyph (
        .code    (code_c),
        .glyph_c (glyph_c)
    );

    // Prescaler, digit pointer and once-per-frame snapshot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            digit      <= 2'd0;
            frame      <= '1;
            frame_tick <= 1'b0;
        end else begin
            if (dwell_end_c) begin
                cnt   <= '0;
                digit <= digit + 2'd1;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
            if (frame_start_c) begin
                frame <= frame_t'(din);
            end
            frame_tick <= frame_start_c;
        end
    end

    // Output registers; anodes stay off during the dead window to stop ghosting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an  <= 4'hF;
            seg <= GLYPH_OFF;
            dp  <= 1'b1;
        end else begin
            an        <= (cnt < CNT_W'(DEAD)) ? 4'hF : ~(4'b0001 << digit);
            {dp, seg} <= glyph_c;
        end
    end

endmodule
